// File: rtl/calc_input_conditioner.sv
// calc_input_conditioner
//   Front end of the calculator datapath. The 8 slide switches and 3 op
//   buttons pass through a 2-FF synchroniser, are debounced as one 11-bit
//   vector, and are committed as a stable {op, operands} snapshot. Each commit
//   produces a one-cycle op_valid strobe. CALC_LATENCY cycles later a
//   one-cycle result_ready strobe marks the point where downstream logic may
//   sample settled results.
//
//   Ports
//     clk, rst      system clock, synchronous active-high reset
//     sw[7:0]       raw slide switches (asynchronous)
//     btn[2:0]      raw op-select buttons (asynchronous)
//     op_code[2:0]  committed op
//     operand_a/b   committed sw[7:4] / sw[3:0]
//     radicand[7:0] committed sw[7:0]
//     op_illegal    committed op_code is 110 or 111
//     op_valid      one-cycle strobe per commit
//     busy          high from commit until result_ready
//     result_ready  one-cycle strobe CALC_LATENCY cycles after op_valid
module calc_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CALC_LATENCY    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sw,
   input  logic [2:0] btn,
   output logic [2:0] op_code,
   output logic [3:0] operand_a,
   output logic [3:0] operand_b,
   output logic [7:0] radicand,
   output logic       op_illegal,
   output logic       op_valid,
   output logic       busy,
   output logic       result_ready
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam int LAT_W = (CALC_LATENCY > 1) ? $clog2(CALC_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(CALC_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_COMMIT,
      S_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [10:0]       sync1_q, vs_q;
   logic [10:0]       cand_q, cand_d;
   logic [10:0]       snap_q, snap_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              op_valid_q, op_valid_d;
   logic              busy_q, busy_d;
   logic              rdy_q, rdy_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sync1_q    <= '0;
         vs_q       <= '0;
         cand_q     <= '0;
         snap_q     <= '0;
         cnt_q      <= '0;
         lat_q      <= '0;
         op_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= {btn, sw};
         vs_q       <= sync1_q;
         cand_q     <= cand_d;
         snap_q     <= snap_d;
         cnt_q      <= cnt_d;
         lat_q      <= lat_d;
         op_valid_q <= op_valid_d;
         busy_q     <= busy_d;
         rdy_q      <= rdy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cand_d     = cand_q;
      snap_d     = snap_q;
      cnt_d      = cnt_q;
      lat_d      = lat_q;
      op_valid_d = 1'b0;
      busy_d     = 1'b0;
      rdy_d      = 1'b0;

      // While a result is in flight the debouncer keeps running, so a change
      // made during COMMIT/WAIT has already accumulated stable time when the
      // result is released.
      if (state_q == S_COMMIT || state_q == S_WAIT) begin
         if (vs_q != cand_q) begin
            cand_d = vs_q;
            cnt_d  = '0;
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (vs_q != snap_q) begin
               cand_d  = vs_q;
               cnt_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (vs_q != cand_q) begin
               cand_d = vs_q;
               cnt_d  = '0;
            end else if (vs_q == snap_q) begin
               // Bounced back to the committed value: nothing to commit.
               state_d = S_IDLE;
            end else if (cnt_q == CNT_MAX) begin
               snap_d  = cand_q;
               state_d = S_COMMIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_COMMIT: begin
            op_valid_d = 1'b1;
            busy_d     = 1'b1;
            lat_d      = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (lat_q == LAT_MAX) begin
               rdy_d = 1'b1;
               // cand_d always equals vs_q after tracking; a differing value
               // resumes debouncing with the count it has already earned.
               state_d = (vs_q != snap_q) ? S_SETTLE : S_IDLE;
            end else begin
               busy_d = 1'b1;
               lat_d  = lat_q + LAT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign op_code      = snap_q[10:8];
   assign operand_a    = snap_q[7:4];
   assign operand_b    = snap_q[3:0];
   assign radicand     = snap_q[7:0];
   assign op_illegal   = snap_q[10] & snap_q[9];
   assign op_valid     = op_valid_q;
   assign busy         = busy_q;
   assign result_ready = rdy_q;

endmodule

// File: tb/tb_calc_input_conditioner.sv
module tb_calc_input_conditioner;

   logic       clk;
   logic       rst;
   logic [7:0] sw;
   logic [2:0] btn;
   logic [2:0] op_code;
   logic [3:0] operand_a;
   logic [3:0] operand_b;
   logic [7:0] radicand;
   logic       op_illegal;
   logic       op_valid;
   logic       busy;
   logic       result_ready;

   calc_input_conditioner #(
      .DEBOUNCE_CYCLES(8),
      .CALC_LATENCY   (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sw          (sw),
      .btn         (btn),
      .op_code     (op_code),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .radicand    (radicand),
      .op_illegal  (op_illegal),
      .op_valid    (op_valid),
      .busy        (busy),
      .result_ready(result_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [10:0] vec;
      logic        ill;
      int          at;
   } exp_t;

   exp_t exp_q[$];
   int   rdy_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      int   r;
      if (rst) begin
         rdy_q.delete();
         chk("rst_op_code", 32'(op_code), 32'd0);
         chk("rst_operand_a", 32'(operand_a), 32'd0);
         chk("rst_operand_b", 32'(operand_b), 32'd0);
         chk("rst_radicand", 32'(radicand), 32'd0);
         chk("rst_op_illegal", 32'(op_illegal), 32'd0);
         chk("rst_op_valid", 32'(op_valid), 32'd0);
         chk("rst_result_ready", 32'(result_ready), 32'd0);
      end
      if (op_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_op_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("op_valid_cycle", 32'(cyc), 32'(e.at));
            chk("op_code", 32'(op_code), 32'(e.vec[10:8]));
            chk("operand_a", 32'(operand_a), 32'(e.vec[7:4]));
            chk("operand_b", 32'(operand_b), 32'(e.vec[3:0]));
            chk("radicand", 32'(radicand), 32'(e.vec[7:0]));
            chk("op_illegal", 32'(op_illegal), 32'(e.ill));
         end
         rdy_q.push_back(cyc + 4);
      end
      if (result_ready) begin
         if (rdy_q.size() == 0) begin
            chk("unexpected_result_ready", 32'd1, 32'd0);
         end else begin
            r = rdy_q.pop_front();
            chk("result_ready_cycle", 32'(cyc), 32'(r));
         end
      end
      chk("busy", 32'(busy), 32'(rdy_q.size() != 0));
   end

   task automatic drive(input logic [10:0] v, output int k);
      @(negedge clk);
      #1;
      {btn, sw} = v;
      k = cyc;
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_commit(input logic [10:0] v, input logic ill, input int at);
      exp_t e;
      e.vec = v;
      e.ill = ill;
      e.at  = at;
      exp_q.push_back(e);
   endtask

   initial begin
      int k;
      rst = 1'b1;
      sw  = 8'h00;
      btn = 3'b000;
      hold(3);
      @(negedge clk);
      #1;
      rst = 1'b0;

      // 1: clean step, add 5+3
      drive(11'h053, k);
      expect_commit(11'h053, 1'b0, k + 12);
      hold(20);

      // 2: button bounce, then hold sub
      for (int i = 0; i < 5; i++) begin
         drive(11'h153, k);
         hold(2);
         drive(11'h053, k);
         hold(2);
      end
      drive(11'h153, k);
      expect_commit(11'h153, 1'b0, k + 12);
      hold(20);

      // 3: short glitch returns to committed value
      drive(11'h157, k);
      hold(1);
      drive(11'h153, k);
      hold(15);
      chk("glitch_op_code", 32'(op_code), 32'd1);
      chk("glitch_operand_a", 32'(operand_a), 32'd5);
      chk("glitch_operand_b", 32'(operand_b), 32'd3);
      chk("glitch_radicand", 32'(radicand), 32'h53);

      // 4: change one cycle after op_valid
      drive(11'h053, k);
      expect_commit(11'h053, 1'b0, k + 12);
      hold(12);
      drive(11'h024, k);
      expect_commit(11'h024, 1'b0, k + 12);
      hold(25);

      // 5: illegal op, then sqrt of 0x31
      drive(11'h624, k);
      expect_commit(11'h624, 1'b1, k + 12);
      hold(20);
      drive(11'h531, k);
      expect_commit(11'h531, 1'b0, k + 12);
      hold(20);

      // 6: reset during WAIT
      drive(11'h39C, k);
      expect_commit(11'h39C, 1'b0, k + 12);
      hold(13);
      @(negedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;
      k = cyc;
      expect_commit(11'h39C, 1'b0, k + 12);
      hold(25);

      chk("pending_op_valid", 32'(exp_q.size()), 32'd0);
      chk("pending_result_ready", 32'(rdy_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
